ysyx_rf_scoreboard: RTL
=======================

# ysyx_rf_scoreboard

Register-file scoreboard that owns the 16-bit pending-write table consumed by the IDU hazard logic. It records every issued instruction that writes a register, retires entries on writeback commit, and discards speculative entries on a branch flush. It sits between the IDU (issue side), the WBU (commit side) and the branch resolution logic, and exports per-register busy status so the IDU can stall on RAW hazards.

## Interface

Parameters:
- NR_REG, 16, number of tracked architectural registers (RV32E); index 0 is never tracked.
- CNT_W, 2, width of each per-register outstanding-write counter (forced to 1 when the `_EN` macro below is absent).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  IDU hands off an instruction this cycle.
- issue_wen  in  1  issued instruction writes rd.
- issue_rd  in  4  destination register of issued instruction.
- issue_spec  in  1  issued instruction is speculative (behind an unresolved branch).
- issue_ready  out  1  scoreboard can accept the issue for issue_rd.
- commit_valid  in  1  WBU writes a register this cycle.
- commit_rd  in  4  register written by commit.
- resolve  in  1  outstanding speculation confirmed correct.
- flush  in  1  outstanding speculation wrong; discard speculative entries.
- rs1  in  4  IDU source query 1.
- rs2  in  4  IDU source query 2.
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- rf_table  out  16  bit r = 1 iff register r has at least one pending write.
- spec_pending  out  1  at least one speculative entry is outstanding.

## Operation

- State per register r (1..15): cnt[r] (CNT_W bits, total outstanding writes) and scnt[r] (CNT_W bits, speculative subset, scnt ≤ cnt). Register 0 is hard-wired to cnt = scnt = 0.
- An issue is accepted when issue_valid & issue_wen & issue_ready & !flush & issue_rd != 0. An accepted issue increments cnt[issue_rd], and also increments scnt[issue_rd] if issue_spec = 1.
- A commit decrements cnt[commit_rd] when commit_valid & commit_rd != 0. Commits are non-speculative by protocol. A commit to a register where cnt == scnt, or where cnt == 0, is a protocol error; cnt holds at 0, and the bench flags the error.
- On resolve, all scnt are cleared to 0 (entries become non-speculative).
- On flush, for every r: cnt[r] -= scnt[r], then scnt[r] = 0.
- issue_ready = (issue_rd == 0) | (cnt[issue_rd] != MAX) | (commit_valid & commit_rd == issue_rd), where MAX = 2^CNT_W − 1. The signal is combinational.
- rf_table[r] = (cnt[r] != 0). rs1_busy = rf_table[rs1] and rs2_busy = rf_table[rs2]. Both read registered state only; there is no same-cycle bypass of issue or commit.
- spec_pending = OR over r of (scnt[r] != 0).
- Simultaneous events within one cycle:
  - Issue and commit to the same register: cnt is unchanged. scnt increments if issue_spec = 1.
  - Flush and issue: the issue is dropped, so the IDU must not count it as accepted. Any commit in the same cycle still applies.
  - Resolve and speculative issue: prior scnt entries clear, and the new issue is counted speculative (scnt = 1).
  - Resolve and flush both asserted: flush wins.

## Timing

- Reset: all cnt and scnt go to 0. rf_table = 0, rs1_busy = rs2_busy = 0, spec_pending = 0, and issue_ready = 1 one cycle after rst falls, with rst held ≥ 1 cycle.
- Reset asserted mid-operation clears all entries on that edge. In-flight issues and commits in that cycle are ignored.
- Issue, commit, resolve and flush take effect on the next rising edge and are visible on rf_table, busy and spec_pending one cycle later (latency 1).
- issue_ready depends combinationally on issue_rd, commit_valid and commit_rd within the same cycle.

## Configuration

- YSYX_SCOREBOARD_COUNT_EN defined: CNT_W as parameterised (default 2). Up to 3 outstanding writes per register are allowed, which supports WAW back-to-back issue.
- Not defined: CNT_W = 1. A second write to a busy register stalls (issue_ready = 0) unless the same register commits in the same cycle.

## Test plan

- Reset then idle: rf_table = 0x0000, issue_ready = 1, spec_pending = 0. Issue to rd = 0 → rf_table stays 0x0000.
- Issue rd = 5 non-spec, then query rs1 = 5 → rs1_busy = 1 next cycle, rf_table = 0x0020. Commit rd = 5 → rf_table = 0x0000 one cycle later.
- With COUNT_EN: 3 issues to rd = 3 → cnt = 3 and issue_ready = 0 for rd = 3. A commit plus issue to rd = 3 in the same cycle is accepted and cnt stays 3. Without COUNT_EN: the second issue to rd = 3 gives issue_ready = 0.
- Issue rd = 2 non-spec, then rd = 2 spec and rd = 7 spec, then flush → rf_table = 0x0004 and spec_pending = 0. A flush with a simultaneous issue to rd = 9 leaves rf_table[9] = 0.
- Spec issue rd = 4, then resolve on the same cycle as spec issue rd = 6 → scnt[4] = 0 and scnt[6] = 1. A subsequent flush leaves rf_table = 0x0010.
- Assert rst with rf_table = 0x00F0 and a commit in flight → next cycle rf_table = 0x0000 and spec_pending = 0.

Source files
------------

// File: rtl/ysyx_rf_scoreboard.sv
// ysyx_rf_scoreboard
//   Pending-write table for the IDU RAW hazard check. Every accepted issue that
//   writes a register bumps that register's outstanding-write counter. A WBU
//   commit retires one write. Speculative issues are also counted in a
//   per-register speculative counter. That counter is cleared when the branch
//   resolves. On a flush, its count is subtracted from the total.
//
//   Optional feature macro: YSYX_SCOREBOARD_COUNT_EN
//     defined   -> counters are CNT_W bits wide (multiple outstanding writes,
//                  WAW back-to-back issue allowed).
//     undefined -> counters are 1 bit wide (a second write to a busy register
//                  stalls unless that register commits in the same cycle).
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     issue_valid/wen/rd/spec  issue side from the IDU
//     issue_ready              combinational accept for issue_rd
//     commit_valid/rd          writeback commit from the WBU
//     resolve, flush           branch outcome (flush wins if both are set)
//     rs1, rs2 -> rs1_busy/rs2_busy  source queries (registered state only)
//     rf_table                 bit r set while register r has a pending write
//     spec_pending             some speculative entry is outstanding
//
//   Handshake: an issue is taken on the rising edge when issue_valid,
//   issue_wen and issue_ready are all high, flush is low and issue_rd != 0.
//   issue_ready never depends on issue_valid.
module ysyx_rf_scoreboard #(
   parameter int NR_REG = 16,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_wen,
   input  logic [3:0]        issue_rd,
   input  logic              issue_spec,
   output logic              issue_ready,
   input  logic              commit_valid,
   input  logic [3:0]        commit_rd,
   input  logic              resolve,
   input  logic              flush,
   input  logic [3:0]        rs1,
   input  logic [3:0]        rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic [NR_REG-1:0] rf_table,
   output logic              spec_pending
);

`ifdef YSYX_SCOREBOARD_COUNT_EN
   localparam int CW = CNT_W;
`else
   localparam int CW = 1;
`endif

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt      [NR_REG];
   logic [CW-1:0] scnt     [NR_REG];
   logic [CW-1:0] cnt_nxt  [NR_REG];
   logic [CW-1:0] scnt_nxt [NR_REG];

   logic issue_acc;
   logic commit_act;

   // A full counter can still take an issue if the same register retires a
   // write this cycle: the increment and decrement cancel.
   assign issue_ready = (issue_rd == 4'd0)
                      | (cnt[issue_rd] != CNT_MAX)
                      | (commit_valid & (commit_rd == issue_rd));

   assign issue_acc  = issue_valid & issue_wen & issue_ready & ~flush & (issue_rd != 4'd0);
   assign commit_act = commit_valid & (commit_rd != 4'd0);

   always_comb begin
      for (int r = 0; r < NR_REG; r++) begin
         cnt_nxt[r]  = cnt[r];
         scnt_nxt[r] = scnt[r];
         // Flush removes the speculative writes first. Resolve only clears
         // the speculative tag, so a new speculative issue that arrives with
         // resolve still counts as speculative.
         if (flush) begin
            cnt_nxt[r]  = cnt[r] - scnt[r];
            scnt_nxt[r] = CNT_ZERO;
         end else if (resolve) begin
            scnt_nxt[r] = CNT_ZERO;
         end
         // A commit with nothing left to retire is a protocol error; hold at 0.
         if (commit_act && (commit_rd == 4'(r)) && (cnt_nxt[r] != CNT_ZERO)) begin
            cnt_nxt[r] = cnt_nxt[r] - CNT_ONE;
         end
         if (issue_acc && (issue_rd == 4'(r))) begin
            cnt_nxt[r] = cnt_nxt[r] + CNT_ONE;
            if (issue_spec) begin
               scnt_nxt[r] = scnt_nxt[r] + CNT_ONE;
            end
         end
         if (r == 0) begin
            cnt_nxt[r]  = CNT_ZERO;
            scnt_nxt[r] = CNT_ZERO;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < NR_REG; r++) begin
         if (rst) begin
            cnt[r]  <= CNT_ZERO;
            scnt[r] <= CNT_ZERO;
         end else begin
            cnt[r]  <= cnt_nxt[r];
            scnt[r] <= scnt_nxt[r];
         end
      end
   end

   always_comb begin
      rf_table     = '0;
      spec_pending = 1'b0;
      for (int r = 0; r < NR_REG; r++) begin
         rf_table[r]  = (cnt[r] != CNT_ZERO);
         spec_pending = spec_pending | (scnt[r] != CNT_ZERO);
      end
   end

   assign rs1_busy = rf_table[rs1];
   assign rs2_busy = rf_table[rs2];

endmodule
